// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings plus transfer legality and byte-lane helpers
// for the ahb_lite_sram slave.
package ahb_lite_pkg;

    localparam int MEM_DW = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [1:0] HRESP_OKAY  = 2'd0;
    localparam logic [1:0] HRESP_ERROR = 2'd1;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ST_OKAY,
        ST_ERR1,
        ST_ERR2
    } err_state_t;

    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~lo[0];
            HSIZE_WORD: ok = (lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Little-endian lane selection; only meaningful for legal transfers.
    function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] lanes;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << lo;
            HSIZE_HALF: lanes = lo[1] ? 4'b1100 : 4'b0011;
            default:    lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/ahb_lite_sram_if.sv
// AHB-Lite bus bundle between a master (or bench) and the SRAM slave.
interface ahb_lite_sram_if #(parameter int mem_abit = 10);

    logic                 hsel;
    logic [mem_abit+1:0]  haddr;
    logic [2:0]           hburst;
    logic [1:0]           htrans;
    logic [2:0]           hsize;
    logic [3:0]           hprot;
    logic                 hwrite;
    logic [31:0]          hwdata;
    logic                 hready;
    logic                 hreadyout;
    logic [31:0]          hrdata;
    logic [1:0]           hresp;

    modport master (
        output hsel, haddr, hburst, htrans, hsize, hprot, hwrite, hwdata, hready,
        input  hreadyout, hrdata, hresp
    );

    modport slave (
        input  hsel, haddr, hburst, htrans, hsize, hprot, hwrite, hwdata, hready,
        output hreadyout, hrdata, hresp
    );

endinterface

// File: rtl/sram_1rw_be.sv
// Single-port SRAM with combinational read and byte-enabled synchronous write.
module sram_1rw_be
    import ahb_lite_pkg::*;
#(
    parameter int mem_depth = 1024,
    parameter int mem_abit  = 10
) (
    input  logic                clk,
    input  logic                we,
    input  logic [3:0]          be,
    input  logic [mem_abit-1:0] addr,
    input  logic [MEM_DW-1:0]   wdata,
    output logic [MEM_DW-1:0]   rdata
);

    logic [MEM_DW-1:0] mem [mem_depth];

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we && be[k]) begin
                mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram.sv
// Zero-wait-state AHB-Lite slave in front of a byte-enabled SRAM; illegal
// sizes or misaligned addresses get the two-cycle ERROR response.
module ahb_lite_sram
    import ahb_lite_pkg::*;
#(
    parameter int mem_depth = 1024,
    parameter int mem_abit  = 10
) (
    input  logic             clk,
    input  logic             rstn,
    ahb_lite_sram_if.slave   bus
);

    err_state_t           state;
    err_state_t           state_nxt;
    logic                 accept;
    logic                 legal;
    logic                 dp_valid;
    logic                 dp_write;
    logic [2:0]           dp_size;
    logic [mem_abit+1:0]  dp_addr;
    logic                 we;
    logic [3:0]           be;
    logic [MEM_DW-1:0]    mem_rdata;
    logic                 unused_ok;

    // The first error cycle never accepts an address, even if hready is tied high.
    assign accept = bus.hsel & bus.hready & bus.htrans[1] & (state != ST_ERR1);
    assign legal  = is_legal(bus.hsize, bus.haddr[1:0]);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_size  <= HSIZE_WORD;
            dp_addr  <= '0;
        end else if (bus.hready) begin
            dp_valid <= accept & legal;
            dp_write <= bus.hwrite;
            dp_size  <= bus.hsize;
            dp_addr  <= bus.haddr;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= ST_OKAY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.hreadyout = 1'b1;
        bus.hresp     = HRESP_OKAY;
        bus.hrdata    = '0;
        case (state)
            ST_ERR1: begin
                state_nxt     = ST_ERR2;
                bus.hreadyout = 1'b0;
                bus.hresp     = HRESP_ERROR;
            end
            ST_ERR2: begin
                bus.hresp = HRESP_ERROR;
                state_nxt = (accept && !legal) ? ST_ERR1 : ST_OKAY;
            end
            default: begin
                state_nxt = (accept && !legal) ? ST_ERR1 : ST_OKAY;
                if (dp_valid && !dp_write) begin
                    bus.hrdata = mem_rdata;
                end
            end
        endcase
    end

    assign be = byte_enable(dp_size, dp_addr[1:0]);
    assign we = dp_valid & dp_write & bus.hready;

    // Burst type and protection carry no meaning for a flat, explicitly addressed memory.
    assign unused_ok = ^{bus.hburst, bus.hprot, bus.htrans[0]};

    sram_1rw_be #(
        .mem_depth (mem_depth),
        .mem_abit  (mem_abit)
    ) u_sram (
        .clk   (clk),
        .we    (we),
        .be    (be),
        .addr  (dp_addr[mem_abit+1:2]),
        .wdata (bus.hwdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_lite_sram.sv
// Directed bench for ahb_lite_sram: single, byte/halfword, burst, BUSY/IDLE,
// error-response and asynchronous-reset sequences with hand-computed results.
module tb_ahb_lite_sram;
    import ahb_lite_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    ahb_lite_sram_if #(.mem_abit(10)) bus ();

    assign bus.hready = bus.hreadyout;

    ahb_lite_sram #(
        .mem_depth (1024),
        .mem_abit  (10)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] trans, input logic write, input logic [2:0] size,
                                  input logic [11:0] addr, input logic [2:0] burst, input logic [31:0] wdata);
        bus.hsel   = 1'b1;
        bus.htrans = trans;
        bus.hwrite = write;
        bus.hsize  = size;
        bus.haddr  = addr;
        bus.hburst = burst;
        bus.hwdata = wdata;
    endtask

    task automatic idle_phase(input logic [31:0] wdata);
        bus.hsel   = 1'b0;
        bus.htrans = HTRANS_IDLE;
        bus.hwrite = 1'b0;
        bus.hsize  = HSIZE_WORD;
        bus.haddr  = '0;
        bus.hburst = HBURST_SINGLE;
        bus.hwdata = wdata;
    endtask

    // Samples the current cycle's data-phase outputs, then moves just past the next edge.
    task automatic expect_cycle(input string tag, input logic ready, input logic [1:0] resp, input logic [31:0] rdata);
        @(negedge clk);
        check_output({tag, ".hreadyout"}, {31'd0, bus.hreadyout}, {31'd0, ready});
        check_output({tag, ".hresp"}, {30'd0, bus.hresp}, {30'd0, resp});
        check_output({tag, ".hrdata"}, bus.hrdata, rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn      = 1'b1;
        bus.hprot = 4'b0011;
        idle_phase(32'h0);
        repeat (2) @(posedge clk);
        #1;
        expect_cycle("reset", 1'b1, HRESP_OKAY, 32'h0);
        rstn = 1'b0;

        // Single word write then read
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h010, HBURST_SINGLE, 32'h0);
        expect_cycle("t1_idle", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h010, HBURST_SINGLE, 32'hDEADBEEF);
        expect_cycle("t1_wr", 1'b1, HRESP_OKAY, 32'h0);
        idle_phase(32'h0);
        expect_cycle("t1_rd", 1'b1, HRESP_OKAY, 32'hDEADBEEF);

        // Byte lanes with junk in the unselected lanes, then a halfword overwrite
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 12'h020, HBURST_SINGLE, 32'h0);
        expect_cycle("t2_a", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 12'h021, HBURST_SINGLE, 32'hEEEEEE11);
        expect_cycle("t2_b0", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 12'h022, HBURST_SINGLE, 32'hEEEE22EE);
        expect_cycle("t2_b1", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 12'h023, HBURST_SINGLE, 32'hEE33EEEE);
        expect_cycle("t2_b2", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h020, HBURST_SINGLE, 32'h44EEEEEE);
        expect_cycle("t2_b3", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 12'h022, HBURST_SINGLE, 32'h0);
        expect_cycle("t2_rd", 1'b1, HRESP_OKAY, 32'h44332211);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h020, HBURST_SINGLE, 32'hAAAA5555);
        expect_cycle("t2_hw", 1'b1, HRESP_OKAY, 32'h0);
        idle_phase(32'h0);
        expect_cycle("t2_rd2", 1'b1, HRESP_OKAY, 32'hAAAA2211);

        // INCR4 write burst immediately followed by INCR4 read
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h100, HBURST_INCR4, 32'h0);
        expect_cycle("t3_a", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b1, HSIZE_WORD, 12'h104, HBURST_INCR4, 32'd1);
        expect_cycle("t3_w0", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b1, HSIZE_WORD, 12'h108, HBURST_INCR4, 32'd2);
        expect_cycle("t3_w1", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b1, HSIZE_WORD, 12'h10C, HBURST_INCR4, 32'd3);
        expect_cycle("t3_w2", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h100, HBURST_INCR4, 32'd4);
        expect_cycle("t3_w3", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b0, HSIZE_WORD, 12'h104, HBURST_INCR4, 32'h0);
        expect_cycle("t3_r0", 1'b1, HRESP_OKAY, 32'd1);
        apply_stimulus(HTRANS_SEQ, 1'b0, HSIZE_WORD, 12'h108, HBURST_INCR4, 32'h0);
        expect_cycle("t3_r1", 1'b1, HRESP_OKAY, 32'd2);
        apply_stimulus(HTRANS_SEQ, 1'b0, HSIZE_WORD, 12'h10C, HBURST_INCR4, 32'h0);
        expect_cycle("t3_r2", 1'b1, HRESP_OKAY, 32'd3);
        idle_phase(32'h0);
        expect_cycle("t3_r3", 1'b1, HRESP_OKAY, 32'd4);

        // WRAP4 from 0x108: beats 0x108, 0x10C, 0x100, 0x104
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h108, HBURST_WRAP4, 32'h0);
        expect_cycle("t3b_a", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b1, HSIZE_WORD, 12'h10C, HBURST_WRAP4, 32'h10);
        expect_cycle("t3b_w0", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b1, HSIZE_WORD, 12'h100, HBURST_WRAP4, 32'h20);
        expect_cycle("t3b_w1", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b1, HSIZE_WORD, 12'h104, HBURST_WRAP4, 32'h30);
        expect_cycle("t3b_w2", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h108, HBURST_WRAP4, 32'h40);
        expect_cycle("t3b_w3", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b0, HSIZE_WORD, 12'h10C, HBURST_WRAP4, 32'h0);
        expect_cycle("t3b_r0", 1'b1, HRESP_OKAY, 32'h10);
        apply_stimulus(HTRANS_SEQ, 1'b0, HSIZE_WORD, 12'h100, HBURST_WRAP4, 32'h0);
        expect_cycle("t3b_r1", 1'b1, HRESP_OKAY, 32'h20);
        apply_stimulus(HTRANS_SEQ, 1'b0, HSIZE_WORD, 12'h104, HBURST_WRAP4, 32'h0);
        expect_cycle("t3b_r2", 1'b1, HRESP_OKAY, 32'h30);
        idle_phase(32'h0);
        expect_cycle("t3b_r3", 1'b1, HRESP_OKAY, 32'h40);

        // Back-to-back write/read, then BUSY, IDLE and unselected cycles must not touch memory
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h040, HBURST_SINGLE, 32'h0);
        expect_cycle("t4_a", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h040, HBURST_SINGLE, 32'h5A5A5A5A);
        expect_cycle("t4_wr", 1'b1, HRESP_OKAY, 32'h0);
        idle_phase(32'h0);
        expect_cycle("t4_rd", 1'b1, HRESP_OKAY, 32'h5A5A5A5A);
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h058, HBURST_SINGLE, 32'h0);
        expect_cycle("t4_b", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h050, HBURST_INCR, 32'h58585858);
        expect_cycle("t4_w58", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_BUSY, 1'b1, HSIZE_WORD, 12'h054, HBURST_INCR, 32'h50505050);
        expect_cycle("t4_w50", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b1, HSIZE_WORD, 12'h054, HBURST_INCR, 32'hBAD0BAD0);
        expect_cycle("t4_busy", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_IDLE, 1'b1, HSIZE_WORD, 12'h058, HBURST_INCR, 32'h54545454);
        expect_cycle("t4_w54", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h058, HBURST_SINGLE, 32'hDEAD0058);
        bus.hsel = 1'b0;
        expect_cycle("t4_idle", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h058, HBURST_SINGLE, 32'hFEEDFACE);
        expect_cycle("t4_nosel", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h050, HBURST_SINGLE, 32'h0);
        expect_cycle("t4_r58", 1'b1, HRESP_OKAY, 32'h58585858);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h054, HBURST_SINGLE, 32'h0);
        expect_cycle("t4_r50", 1'b1, HRESP_OKAY, 32'h50505050);
        idle_phase(32'h0);
        expect_cycle("t4_r54", 1'b1, HRESP_OKAY, 32'h54545454);

        // Misaligned word write: two-cycle ERROR, address during cycle 1 ignored, memory untouched
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h000, HBURST_SINGLE, 32'h0);
        expect_cycle("t5_a", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h002, HBURST_SINGLE, 32'h12345678);
        expect_cycle("t5_w0", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h000, HBURST_SINGLE, 32'hCAFEF00D);
        expect_cycle("t5_err1", 1'b0, HRESP_ERROR, 32'h0);
        idle_phase(32'hBADBAD00);
        expect_cycle("t5_err2", 1'b1, HRESP_ERROR, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h000, HBURST_SINGLE, 32'h0);
        expect_cycle("t5_after", 1'b1, HRESP_OKAY, 32'h0);
        idle_phase(32'h0);
        expect_cycle("t5_rd", 1'b1, HRESP_OKAY, 32'h12345678);

        // Oversized read (hsize=3) also errors and returns zero data
        apply_stimulus(HTRANS_NONSEQ, 1'b0, 3'd3, 12'h000, HBURST_SINGLE, 32'h0);
        expect_cycle("t5_sz_a", 1'b1, HRESP_OKAY, 32'h0);
        idle_phase(32'h0);
        expect_cycle("t5_sz_err1", 1'b0, HRESP_ERROR, 32'h0);
        idle_phase(32'h0);
        expect_cycle("t5_sz_err2", 1'b1, HRESP_ERROR, 32'h0);

        // Misaligned halfword write; next read is presented during the second error cycle
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 12'h021, HBURST_SINGLE, 32'h0);
        expect_cycle("t5_hw_a", 1'b1, HRESP_OKAY, 32'h0);
        idle_phase(32'h99999999);
        expect_cycle("t5_hw_err1", 1'b0, HRESP_ERROR, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h020, HBURST_SINGLE, 32'h99999999);
        expect_cycle("t5_hw_err2", 1'b1, HRESP_ERROR, 32'h0);
        idle_phase(32'h0);
        expect_cycle("t5_hw_rd", 1'b1, HRESP_OKAY, 32'hAAAA2211);

        // Asynchronous reset in the middle of a write burst
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h204, HBURST_SINGLE, 32'h0);
        expect_cycle("t6_a", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 12'h200, HBURST_INCR, 32'h77777777);
        expect_cycle("t6_pre", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b1, HSIZE_WORD, 12'h204, HBURST_INCR, 32'h00000200);
        expect_cycle("t6_w0", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_SEQ, 1'b1, HSIZE_WORD, 12'h208, HBURST_INCR, 32'h00000204);
        #2;
        rstn = 1'b1;
        #1;
        check_output("t6_rst.hreadyout", {31'd0, bus.hreadyout}, 32'd1);
        check_output("t6_rst.hresp", {30'd0, bus.hresp}, 32'd0);
        check_output("t6_rst.hrdata", bus.hrdata, 32'h0);
        idle_phase(32'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h200, HBURST_SINGLE, 32'h0);
        expect_cycle("t6_rel", 1'b1, HRESP_OKAY, 32'h0);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h204, HBURST_SINGLE, 32'h0);
        expect_cycle("t6_r200", 1'b1, HRESP_OKAY, 32'h00000200);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h010, HBURST_SINGLE, 32'h0);
        expect_cycle("t6_r204", 1'b1, HRESP_OKAY, 32'h77777777);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h100, HBURST_SINGLE, 32'h0);
        expect_cycle("t6_r010", 1'b1, HRESP_OKAY, 32'hDEADBEEF);
        apply_stimulus(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 12'h010, HBURST_SINGLE, 32'h0);
        expect_cycle("t6_r100", 1'b1, HRESP_OKAY, 32'h30);

        // Reset during a read data phase must zero hrdata immediately
        idle_phase(32'h0);
        #1;
        check_output("t6_rd_live.hrdata", bus.hrdata, 32'hDEADBEEF);
        rstn = 1'b1;
        #1;
        check_output("t6_rd_rst.hrdata", bus.hrdata, 32'h0);
        check_output("t6_rd_rst.hreadyout", {31'd0, bus.hreadyout}, 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        expect_cycle("t6_end", 1'b1, HRESP_OKAY, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_lite_sram.md
Name: ahb_lite_sram

Overview:
- AHB-Lite slave that fronts an on-chip single-port SRAM of mem_depth 32-bit words.
- Zero-wait-state for legal transfers; supports all burst types and 8/16/32-bit transfers.
- Sits on the AHB-Lite bus and is driven by the ahb_lite_ms_model master/monitor in the block bench.

Parameters:
- mem_depth, 1024, number of 32-bit words; must equal 2**mem_abit.
- mem_abit, 10, word-address width.
- mem_dw, 32, data width; fixed at 32, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-high reset. Asserted when 1 despite the name.
- hsel  in  1  slave select.
- haddr  in  mem_abit+2  byte address.
- hburst  in  3  burst type; accepted and otherwise ignored (each beat is addressed explicitly).
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hsize  in  3  0=byte, 1=halfword, 2=word.
- hprot  in  4  ignored.
- hwrite  in  1  1=write, 0=read.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-level ready; the address phase is valid only when this is 1.
- hreadyout  out  1  slave ready.
- hrdata  out  32  read data.
- hresp  out  2  0=OKAY, 1=ERROR.

Behaviour:
- Address phase accepted: hsel & hready & htrans[1]=1.
  - On the rising edge, register: valid flag, hwrite, hsize, haddr.
  - IDLE/BUSY, or hsel=0: the next data phase is empty, with an OKAY zero-wait response.
- Legal transfer:
  - hsize<=2, and aligned (halfword needs haddr[0]=0; word needs haddr[1:0]=0).
- Word index: haddr[mem_abit+1:2]. Byte lanes are little-endian; lane k = bits 8k+7:8k.
- Write, data phase:
  - hreadyout=1, hresp=OKAY.
  - At the end-of-data-phase rising edge, write the hwdata lanes selected by the registered hsize/haddr[1:0].
  - Byte writes one lane, halfword writes two lanes, word writes four; other lanes are unchanged.
- Read, data phase:
  - hrdata = full 32-bit word mem[registered word index], driven combinationally from the array; all lanes are driven.
  - Zero wait states.
- Read-after-write:
  - A write data phase commits at its closing edge, before any following read's data phase.
  - Back-to-back write→read to the same address returns the new data without stalls.
- hrdata outside read data phases: 0.
- Illegal transfer (hsize>=3 or misaligned), two-cycle ERROR:
  - Cycle 1: hreadyout=0, hresp=1.
  - Cycle 2: hreadyout=1, hresp=1.
  - Memory is not written and hrdata=0.
  - An address phase presented during cycle 1 is ignored because hready=0.
- Reset: hreadyout=1, hresp=0, hrdata=0, data-phase valid flag cleared.
  - Memory contents are not reset; they are undefined until written.
  - Reset asserted mid-transfer aborts the transfer; no partial write occurs.
- Address wrap: out-of-range addresses cannot occur, because haddr width exactly covers mem_depth words.

Decomposition:
- Shared package ahb_lite_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HALF/WORD, HRESP_OKAY/ERROR, HBURST codes.
- One sub-module, sram_1rw_be:
  - Parameters mem_depth, mem_abit.
  - Ports clk, we, be[3:0], addr, wdata, rdata.
  - Combinational read, byte-enabled synchronous write.
- ahb_lite_sram contains the data-phase registers, byte-enable decode, error FSM (OKAY, ERR1, ERR2) and output muxing.

Test Plan:
- Word write 0xDEADBEEF to addr 0x010, then word read of 0x010 → hrdata=0xDEADBEEF, hreadyout=1 in every cycle, hresp=0.
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x020–0x023, then word read of 0x020 → 0x44332211. Halfword write 0xAAAA to 0x022, then word read → 0xAAAA2211.
- INCR4 word write burst (NONSEQ + 3 SEQ) at 0x100 with data 1..4, immediately followed by an INCR4 read → 1, 2, 3, 4 with no wait states.
  - Repeat with a WRAP4 burst starting at 0x108: beats at 0x108, 0x10C, 0x100, 0x104.
- Back-to-back write 0x5A5A5A5A to 0x040 followed by a read of 0x040 in the next address phase → 0x5A5A5A5A. BUSY/IDLE cycles inserted mid-burst cause no memory access.
- Word write to 0x002 (misaligned) → one cycle hreadyout=0/hresp=1, then hreadyout=1/hresp=1; a subsequent read of 0x000 returns the unchanged prior value.
- Assert rstn=1 asynchronously mid-write-burst → outputs immediately hreadyout=1, hresp=0, hrdata=0. After release, previously completed writes still read back correctly.
